// File: rtl/zone_probe_pkg.sv
// Shared types and constants for the safe-zone corner probe.
package zone_probe_pkg;

  // Probe controller states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    PROBE    = 2'd2,
    DONE     = 2'd3
  } zone_probe_state_t;

  // A square sprite has four corners to look up
  localparam int CORNER_NUM   = 4;
  localparam int CORNER_IDX_W = $clog2(CORNER_NUM);

endpackage : zone_probe_pkg

// File: rtl/zone_probe.sv
// Walks the four corners of the player sprite through the safe-zone map,
// reports all/any-safe, and tracks consecutive unsafe checks with a hit pulse.
module zone_probe
  import zone_probe_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 800,
  parameter int SCREEN_HEIGHT = 600,
  parameter int PLAYER_SIZE   = 20,
  parameter int HIT_THRESHOLD = 4
) (
  input  logic                                   clk,
  input  logic                                   arst_n,
  input  logic                                   i_check,
  input  logic [$clog2(SCREEN_WIDTH)-1:0]        i_player_x,
  input  logic [$clog2(SCREEN_HEIGHT)-1:0]       i_player_y,
  input  logic                                   i_clear_hits,
  input  logic                                   i_zone_rdy,
  output logic [$clog2(SCREEN_WIDTH)-1:0]        o_zone_x,
  output logic [$clog2(SCREEN_HEIGHT)-1:0]       o_zone_y,
  input  logic                                   i_zone_is_safe,
  output logic                                   o_busy,
  output logic                                   o_valid,
  output logic                                   o_all_safe,
  output logic                                   o_any_safe,
  output logic [$clog2(HIT_THRESHOLD+1)-1:0]     o_unsafe_cnt,
  output logic                                   o_hit
);

  localparam int XW = $clog2(SCREEN_WIDTH);
  localparam int YW = $clog2(SCREEN_HEIGHT);
  localparam int CW = $clog2(HIT_THRESHOLD + 1);

  localparam logic [XW:0]   X_OFFSET = (XW+1)'(PLAYER_SIZE - 1);
  localparam logic [YW:0]   Y_OFFSET = (YW+1)'(PLAYER_SIZE - 1);
  localparam logic [XW:0]   X_LIMIT  = (XW+1)'(SCREEN_WIDTH - 1);
  localparam logic [YW:0]   Y_LIMIT  = (YW+1)'(SCREEN_HEIGHT - 1);
  localparam logic [XW-1:0] X_MAX    = XW'(SCREEN_WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX    = YW'(SCREEN_HEIGHT - 1);
  localparam logic [CW-1:0] HIT_MAX  = CW'(HIT_THRESHOLD);
  localparam logic [CORNER_IDX_W-1:0] LAST_CORNER = CORNER_IDX_W'(CORNER_NUM - 1);

  zone_probe_state_t state_r, state_s;

  logic [CORNER_IDX_W-1:0] idx_r, idx_s;
  logic [CORNER_NUM-1:0]   bits_r, bits_s;
  logic [XW-1:0]           px_r, px_s;
  logic [YW-1:0]           py_r, py_s;

  logic [XW:0]             x_sum_s;
  logic [YW:0]             y_sum_s;
  logic [XW-1:0]           x_far_s;
  logic [YW-1:0]           y_far_s;

  logic [XW-1:0]           zone_x_r, zone_x_s;
  logic [YW-1:0]           zone_y_r, zone_y_s;
  logic                    busy_r, busy_s;
  logic                    valid_r, valid_s;
  logic                    all_r, all_s;
  logic                    any_r, any_s;
  logic [CW-1:0]           cnt_r, cnt_s;
  logic                    hit_r, hit_s;

  // Next-state, corner walk, result and counter update
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    bits_s  = bits_r;
    px_s    = px_r;
    py_s    = py_r;
    valid_s = 1'b0;
    all_s   = all_r;
    any_s   = any_r;
    cnt_s   = cnt_r;
    hit_s   = 1'b0;

    case (state_r)
      IDLE: begin
        if (i_check) begin
          px_s   = i_player_x;
          py_s   = i_player_y;
          idx_s  = {CORNER_IDX_W{1'b0}};
          bits_s = {CORNER_NUM{1'b0}};
          if (i_zone_rdy) begin
            state_s = PROBE;
          end else begin
            state_s = WAIT_RDY;
          end
        end else begin
          state_s = IDLE;
        end
      end

      WAIT_RDY: begin
        if (i_zone_rdy) begin
          state_s = PROBE;
          idx_s   = {CORNER_IDX_W{1'b0}};
          bits_s  = {CORNER_NUM{1'b0}};
        end else begin
          state_s = WAIT_RDY;
        end
      end

      PROBE: begin
        if (!i_zone_rdy) begin
          // Map is regenerating: this sample is stale, restart the walk later
          state_s = WAIT_RDY;
          idx_s   = {CORNER_IDX_W{1'b0}};
          bits_s  = {CORNER_NUM{1'b0}};
        end else begin
          bits_s[idx_r] = i_zone_is_safe;
          if (idx_r == LAST_CORNER) begin
            state_s = DONE;
            valid_s = 1'b1;
            all_s   = &bits_s;
            any_s   = |bits_s;
            if (&bits_s) begin
              cnt_s = {CW{1'b0}};
            end else if (cnt_r == HIT_MAX) begin
              cnt_s = cnt_r;
            end else begin
              cnt_s = cnt_r + CW'(1);
              hit_s = ((cnt_r + CW'(1)) == HIT_MAX);
            end
          end else begin
            idx_s = idx_r + CORNER_IDX_W'(1);
          end
        end
      end

      DONE: begin
        state_s = IDLE;
      end

      default: begin
        state_s = IDLE;
      end
    endcase

    // Clearing wins over any result update in the same cycle
    if (i_clear_hits) begin
      cnt_s = {CW{1'b0}};
      hit_s = 1'b0;
    end else begin
      hit_s = hit_s;
    end
  end

  // Far-edge corner coordinates, computed one bit wide and clamped on-screen
  always_comb begin
    x_sum_s = {1'b0, px_s} + X_OFFSET;
    y_sum_s = {1'b0, py_s} + Y_OFFSET;
    if (x_sum_s > X_LIMIT) begin
      x_far_s = X_MAX;
    end else begin
      x_far_s = x_sum_s[XW-1:0];
    end
    if (y_sum_s > Y_LIMIT) begin
      y_far_s = Y_MAX;
    end else begin
      y_far_s = y_sum_s[YW-1:0];
    end
  end

  // Query address for the coming cycle: bit 0 selects far x, bit 1 far y
  always_comb begin
    busy_s = (state_s != IDLE);
    if (state_s == PROBE) begin
      zone_x_s = idx_s[0] ? x_far_s : px_s;
      zone_y_s = idx_s[1] ? y_far_s : py_s;
    end else begin
      zone_x_s = {XW{1'b0}};
      zone_y_s = {YW{1'b0}};
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_r  <= IDLE;
      idx_r    <= {CORNER_IDX_W{1'b0}};
      bits_r   <= {CORNER_NUM{1'b0}};
      px_r     <= {XW{1'b0}};
      py_r     <= {YW{1'b0}};
      zone_x_r <= {XW{1'b0}};
      zone_y_r <= {YW{1'b0}};
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
      all_r    <= 1'b0;
      any_r    <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      hit_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      idx_r    <= idx_s;
      bits_r   <= bits_s;
      px_r     <= px_s;
      py_r     <= py_s;
      zone_x_r <= zone_x_s;
      zone_y_r <= zone_y_s;
      busy_r   <= busy_s;
      valid_r  <= valid_s;
      all_r    <= all_s;
      any_r    <= any_s;
      cnt_r    <= cnt_s;
      hit_r    <= hit_s;
    end
  end

  assign o_zone_x     = zone_x_r;
  assign o_zone_y     = zone_y_r;
  assign o_busy       = busy_r;
  assign o_valid      = valid_r;
  assign o_all_safe   = all_r;
  assign o_any_safe   = any_r;
  assign o_unsafe_cnt = cnt_r;
  assign o_hit        = hit_r;

endmodule : zone_probe
